z80_ex_unit: RTL and testbench
==============================

# z80_ex_unit

Sequential execution unit for the Z80 exchange family: EX DE,HL; EX AF,AF'; EXX; EX (SP),HL/IX/IY.
- Register-only exchanges complete in one cycle as swap strobes to the register file.
- EX (SP),rr runs a four-transfer memory sequence (two reads, two writes) through the bus controller, then writes back the selected 16-bit register.
- Reports the architectural T-state count so the z80fi checker can compare against the instruction specs.

## Interface
Parameters:
- INDEX_EN, 1, accept DD/FD prefix on EX (SP),rr (IX/IY); 0 makes prefixed E3 illegal
- SHADOW_EN, 1, accept EX AF,AF' and EXX; 0 makes 08/D9 illegal

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin instruction; sampled only when busy=0
- opcode  in  8  opcode byte, sampled with start
- prefix  in  2  00 none, 01 DD (IX), 10 FD (IY), 11 illegal; sampled with start
- sp_in, hl_in, ix_in, iy_in  in  16 each  register values, sampled with start
- busy  out  1  instruction in progress
- done  out  1  one-cycle completion pulse
- illegal  out  1  with done: opcode/prefix not executed
- swap_de_hl, swap_af, swap_exx  out  1 each  one-cycle strobes, coincident with done
- mem_req  out  1  bus request
- mem_we  out  1  1 write, 0 read; valid while mem_req
- mem_addr  out  16  byte address; valid while mem_req
- mem_wdata  out  8  write data; valid while mem_req & mem_we
- mem_rdata  in  8  read data, sampled on edge where mem_req & mem_ack
- mem_ack  in  1  completes current transfer; ignored when mem_req=0
- wr_en  out  1  one-cycle register write strobe, coincident with done
- wr_sel  out  2  00 HL, 01 IX, 10 IY
- wr_data  out  16  value written to register wr_sel
- tcycles  out  5  T-state count, valid with done, else 0

## Operation
- Decode on start (busy=0):
  - EB: EX DE,HL, prefix ignored, swap_de_hl, tcycles 4 (8 if prefixed)
  - 08: EX AF,AF', swap_af, tcycles 4
  - D9: EXX, swap_exx, tcycles 4
  - E3: EX (SP),rr; rr = HL/IX/IY by prefix, tcycles 19 (23 if prefixed)
  - anything else, prefix 11, or disabled by parameter: illegal=1, done=1, no strobe, no bus activity, tcycles 0
- Captured at start: SP, rr value, rr select. Inputs are not re-sampled mid-instruction.
- Exchange states:
  - IDLE -> FIN (register exchanges/illegal) or RD_LO (E3)
  - RD_LO -> RD_HI -> WR_HI -> WR_LO -> FIN -> IDLE
- Memory transfers:
  - RD_LO: read SP, latch lo
  - RD_HI: read SP+1, latch hi
  - WR_HI: write rr[15:8] to SP+1
  - WR_LO: write rr[7:0] to SP
  - SP+1 is modulo 2^16: FFFF -> 0000
  - Each state holds mem_req/mem_addr/mem_we/mem_wdata stable until an edge with mem_ack=1, then advances.
- FIN: done=1, plus the strobe or (E3) wr_en=1, wr_sel=captured select, wr_data={hi,lo}; busy=0 next cycle.
- SP is never modified.
- start while busy=1 is ignored.
- start in the cycle done is high: busy still 1, so ignored.

## Timing
- Reset: all outputs 0; state IDLE; captured registers cleared.
- Reset mid-sequence aborts next edge: no wr_en, no strobe, no done.
- Transfer in progress at reset is dropped; the bus controller sees mem_req fall.
- busy rises the cycle after accepted start; falls the cycle after FIN.
- Register exchange/illegal latency: done in cycle start+1.
- E3 with mem_ack held 1: mem_req high cycles start+1..start+4; done/wr_en in start+5.
  - Each wait cycle (mem_ack=0) adds one cycle.
- mem_req stays high back-to-back across the four transfers when ack is immediate; address/we change only on the ack edge.

## Test plan
- Reset, then start opcode EB prefix 00 -> cycle+1: done=1, swap_de_hl=1, tcycles=4, mem_req never high; prefix 01 -> tcycles=8.
- SHADOW_EN=0, start 08 -> done=1, illegal=1, swap_af=0, tcycles=0; SHADOW_EN=1 -> swap_af=1, tcycles=4.
- E3 prefix 00, sp_in=1000, hl_in=1234, memory 1000=78, 1001=56, ack always 1:
  - reads 1000, 1001
  - writes 1001<=12, 1000<=34
  - done cycle+5: wr_sel=00, wr_data=5678, tcycles=19
- E3 prefix 10, sp_in=FFFF, iy_in=ABCD, 2 wait cycles per transfer:
  - addresses FFFF, 0000, 0000<=AB, FFFF<=CD
  - done cycle+13: wr_sel=10, tcycles=23
- Reset asserted during WR_HI (ack low) -> next cycle all outputs 0, no wr_en/done; a new EB start then completes normally.
- start pulsed during an E3 sequence with opcode D9 -> ignored; no swap_exx, exactly one done.

Source files
------------

// File: rtl/z80_ex_unit.sv
// Z80 exchange-family execution unit: EX DE,HL / EX AF,AF' / EXX as one-cycle swap strobes,
// EX (SP),rr as a read-lo, read-hi, write-hi, write-lo bus sequence followed by a register write.
module z80_ex_unit #(
    parameter bit INDEX_EN  = 1'b1,
    parameter bit SHADOW_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [1:0]  prefix,
    input  logic [15:0] sp_in,
    input  logic [15:0] hl_in,
    input  logic [15:0] ix_in,
    input  logic [15:0] iy_in,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        swap_de_hl,
    output logic        swap_af,
    output logic        swap_exx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        wr_en,
    output logic [1:0]  wr_sel,
    output logic [15:0] wr_data,
    output logic [4:0]  tcycles
);

    typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrHi, StWrLo, StFin} state_t;

    state_t      state_q, state_d;
    logic [15:0] sp_q, rr_q;
    logic [1:0]  sel_q;
    logic [7:0]  lo_q, hi_q;
    logic [2:0]  swap_q;  // {exx, af, de_hl}
    logic        ill_q, mem_op_q;
    logic [4:0]  tc_q;

    logic        dec_ill, dec_mem;
    logic [2:0]  dec_swap;
    logic [4:0]  dec_tc;
    logic [15:0] dec_rr;
    logic [15:0] sp_inc;

    assign sp_inc = sp_q + 16'd1;

    always_comb begin
        dec_ill  = 1'b1;
        dec_mem  = 1'b0;
        dec_swap = 3'b000;
        dec_tc   = 5'd0;
        if (prefix != 2'b11) begin
            case (opcode)
                8'hEB: begin
                    dec_ill  = 1'b0;
                    dec_swap = 3'b001;
                    dec_tc   = (prefix == 2'b00) ? 5'd4 : 5'd8;
                end
                8'h08: if (SHADOW_EN) begin
                    dec_ill  = 1'b0;
                    dec_swap = 3'b010;
                    dec_tc   = 5'd4;
                end
                8'hD9: if (SHADOW_EN) begin
                    dec_ill  = 1'b0;
                    dec_swap = 3'b100;
                    dec_tc   = 5'd4;
                end
                8'hE3: if (prefix == 2'b00 || INDEX_EN) begin
                    dec_ill = 1'b0;
                    dec_mem = 1'b1;
                    dec_tc  = (prefix == 2'b00) ? 5'd19 : 5'd23;
                end
                default: ;
            endcase
        end
        case (prefix)
            2'b01:   dec_rr = ix_in;
            2'b10:   dec_rr = iy_in;
            default: dec_rr = hl_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            sp_q     <= '0;
            rr_q     <= '0;
            sel_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            swap_q   <= '0;
            ill_q    <= 1'b0;
            mem_op_q <= 1'b0;
            tc_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                sp_q     <= sp_in;
                rr_q     <= dec_rr;
                sel_q    <= dec_mem ? prefix : 2'b00;
                swap_q   <= dec_swap;
                ill_q    <= dec_ill;
                mem_op_q <= dec_mem;
                tc_q     <= dec_tc;
            end
            if (state_q == StRdLo && mem_ack) lo_q <= mem_rdata;
            if (state_q == StRdHi && mem_ack) hi_q <= mem_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        illegal    = 1'b0;
        swap_de_hl = 1'b0;
        swap_af    = 1'b0;
        swap_exx   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        wr_en      = 1'b0;
        wr_sel     = 2'b00;
        wr_data    = 16'h0000;
        tcycles    = 5'd0;
        case (state_q)
            StIdle: if (start) state_d = dec_mem ? StRdLo : StFin;
            StRdLo: begin
                mem_req  = 1'b1;
                mem_addr = sp_q;
                if (mem_ack) state_d = StRdHi;
            end
            StRdHi: begin
                mem_req  = 1'b1;
                mem_addr = sp_inc;
                if (mem_ack) state_d = StWrHi;
            end
            StWrHi: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_inc;
                mem_wdata = rr_q[15:8];
                if (mem_ack) state_d = StWrLo;
            end
            StWrLo: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = rr_q[7:0];
                if (mem_ack) state_d = StFin;
            end
            StFin: begin
                done       = 1'b1;
                illegal    = ill_q;
                swap_de_hl = swap_q[0];
                swap_af    = swap_q[1];
                swap_exx   = swap_q[2];
                wr_en      = mem_op_q;
                wr_sel     = mem_op_q ? sel_q : 2'b00;
                wr_data    = mem_op_q ? {hi_q, lo_q} : 16'h0000;
                tcycles    = tc_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_z80_ex_unit.sv
// Bench for z80_ex_unit: directed scenarios plus randomized instructions checked against a
// rule-level model; a second instance with both enables off checks the illegal-decode paths.
module tb_z80_ex_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [7:0]  opcode;
    logic [1:0]  prefix;
    logic [15:0] sp_in, hl_in, ix_in, iy_in;
    logic        busy, done, illegal, swap_de_hl, swap_af, swap_exx;
    logic        mem_req, mem_we, mem_ack, wr_en;
    logic [15:0] mem_addr, wr_data;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [1:0]  wr_sel;
    logic [4:0]  tcycles;

    logic        n_busy, n_done, n_illegal, n_swap_de_hl, n_swap_af, n_swap_exx;
    logic        n_mem_req, n_mem_we, n_wr_en;
    logic [15:0] n_mem_addr, n_wr_data;
    logic [7:0]  n_mem_wdata;
    logic [1:0]  n_wr_sel;
    logic [4:0]  n_tcycles;

    z80_ex_unit dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .prefix(prefix),
        .sp_in(sp_in), .hl_in(hl_in), .ix_in(ix_in), .iy_in(iy_in),
        .busy(busy), .done(done), .illegal(illegal), .swap_de_hl(swap_de_hl),
        .swap_af(swap_af), .swap_exx(swap_exx), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .tcycles(tcycles)
    );

    z80_ex_unit #(.INDEX_EN(1'b0), .SHADOW_EN(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .prefix(prefix),
        .sp_in(sp_in), .hl_in(hl_in), .ix_in(ix_in), .iy_in(iy_in),
        .busy(n_busy), .done(n_done), .illegal(n_illegal), .swap_de_hl(n_swap_de_hl),
        .swap_af(n_swap_af), .swap_exx(n_swap_exx), .mem_req(n_mem_req), .mem_we(n_mem_we),
        .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_rdata(8'h00), .mem_ack(1'b1),
        .wr_en(n_wr_en), .wr_sel(n_wr_sel), .wr_data(n_wr_data), .tcycles(n_tcycles)
    );

    int total = 0;
    int bad   = 0;

    // Memory-side bus model with a configurable number of wait cycles per transfer.
    logic [7:0]  mem [0:65535];
    logic [24:0] log_q [$];
    int          wait_n = 0;
    int          wcnt   = 0;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (wcnt >= wait_n);

    always @(posedge clk) begin
        if (mem_req && mem_ack && !reset) begin
            log_q.push_back({mem_we, mem_addr, mem_wdata});
            if (mem_we) mem[mem_addr] <= mem_wdata;
            wcnt <= 0;
        end else if (mem_req && !reset) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    typedef struct {
        bit       ill;
        bit [2:0] sw;      // {exx, af, de_hl}
        int       tc;
        bit       is_mem;
        bit [1:0] sel;
    } exp_t;

    function automatic exp_t model(input logic [7:0] op, input logic [1:0] pre,
                                   input bit sh_en, input bit ix_en);
        exp_t e;
        e.ill = 1'b1; e.sw = 3'b000; e.tc = 0; e.is_mem = 1'b0; e.sel = 2'b00;
        if (pre == 2'b11) return e;
        if (op == 8'hEB) begin
            e.ill = 1'b0; e.sw = 3'b001; e.tc = (pre == 2'b00) ? 4 : 8;
        end else if (op == 8'h08 && sh_en) begin
            e.ill = 1'b0; e.sw = 3'b010; e.tc = 4;
        end else if (op == 8'hD9 && sh_en) begin
            e.ill = 1'b0; e.sw = 3'b100; e.tc = 4;
        end else if (op == 8'hE3 && (pre == 2'b00 || ix_en)) begin
            e.ill = 1'b0; e.is_mem = 1'b1; e.sel = pre; e.tc = (pre == 2'b00) ? 19 : 23;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one instruction and checks everything observable up to the cycle after done.
    // inj > 0 pulses a D9 start in that cycle, which must be ignored.
    task automatic run_instr(input logic [7:0] op, input logic [1:0] pre, input logic [15:0] sp,
                             input logic [15:0] hl, input logic [15:0] ix, input logic [15:0] iy,
                             input int wn, input int inj);
        exp_t        e, en;
        logic [15:0] rr, sp1;
        logic [7:0]  lo0, hi0;
        logic [24:0] ent;
        logic [15:0] xa [4];
        bit          xw [4];
        logic [7:0]  xd [4];
        int          k;
        bit          got, ns_got, sawreq;
        logic        d_ill, d_wren, ns_ill;
        logic [2:0]  d_sw, ns_sw;
        logic [4:0]  d_tc, ns_tc;
        logic [1:0]  d_sel;
        logic [15:0] d_wd;
        e   = model(op, pre, 1'b1, 1'b1);
        en  = model(op, pre, 1'b0, 1'b0);
        rr  = (pre == 2'b01) ? ix : (pre == 2'b10) ? iy : hl;
        sp1 = sp + 16'd1;
        lo0 = mem[sp];
        hi0 = mem[sp1];
        log_q.delete();
        got = 0; ns_got = 0; sawreq = 0; k = 0;
        d_ill = 0; d_wren = 0; d_sw = 0; d_tc = 0; d_sel = 0; d_wd = 0;
        ns_ill = 0; ns_sw = 0; ns_tc = 0;
        @(negedge clk);
        opcode = op; prefix = pre; sp_in = sp; hl_in = hl; ix_in = ix; iy_in = iy;
        wait_n = wn; start = 1'b1;
        while (k < 200 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                sp_in = 16'($urandom); hl_in = 16'($urandom);
                ix_in = 16'($urandom); iy_in = 16'($urandom);
                chk("busy_rise", busy, 1);
            end
            if (inj > 0 && k == inj) begin
                start = 1'b1; opcode = 8'hD9; prefix = 2'b00;
            end
            if (inj > 0 && k == inj + 1) start = 1'b0;
            if (mem_req) sawreq = 1;
            if (n_done && !ns_got) begin
                ns_got = 1; ns_ill = n_illegal; ns_tc = n_tcycles;
                ns_sw = {n_swap_exx, n_swap_af, n_swap_de_hl};
            end
            if (done) begin
                got = 1; d_ill = illegal; d_wren = wr_en; d_sel = wr_sel; d_wd = wr_data;
                d_sw = {swap_exx, swap_af, swap_de_hl}; d_tc = tcycles;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("latency", k, e.is_mem ? 5 + 4 * wn : 1);
        chk("illegal", d_ill, e.ill);
        chk("strobes", d_sw, e.sw);
        chk("tcycles", d_tc, e.tc);
        chk("wr_en", d_wren, e.is_mem);
        chk("bus_used", sawreq, e.is_mem);
        chk("xfer_count", log_q.size(), e.is_mem ? 4 : 0);
        if (e.is_mem) begin
            chk("wr_sel", d_sel, e.sel);
            chk("wr_data", d_wd, {hi0, lo0});
            chk("mem_lo", mem[sp], rr[7:0]);
            chk("mem_hi", mem[sp1], rr[15:8]);
            xa = '{sp, sp1, sp1, sp};
            xw = '{0, 0, 1, 1};
            xd = '{8'h00, 8'h00, rr[15:8], rr[7:0]};
            if (log_q.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    ent = log_q[i];
                    chk("xfer_we_addr", ent[24:8], {xw[i], xa[i]});
                    if (xw[i]) chk("xfer_wdata", ent[7:0], xd[i]);
                end
            end
        end
        chk("ns_done", ns_got, 1);
        chk("ns_illegal", ns_ill, en.ill);
        chk("ns_strobes", ns_sw, en.sw);
        chk("ns_tcycles", ns_tc, en.tc);
        @(negedge clk);
        chk("busy_fall", busy, 0);
        chk("single_done", done, 0);
    endtask

    logic [7:0]  op;
    logic [15:0] sp;
    logic [7:0]  keep_hi;
    bit          found, seen;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        reset = 1'b1; start = 1'b0; opcode = 8'h00; prefix = 2'b00;
        sp_in = 16'h0; hl_in = 16'h0; ix_in = 16'h0; iy_in = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {busy, done, illegal, swap_de_hl, swap_af, swap_exx, mem_req, mem_we,
                         wr_en}, 0);
        chk("rst_data", {mem_addr, mem_wdata, wr_sel, wr_data, tcycles}, 0);
        reset = 1'b0;

        run_instr(8'hEB, 2'b00, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 0, 0);
        run_instr(8'hEB, 2'b01, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 0, 0);
        run_instr(8'hEB, 2'b11, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 0, 0);
        run_instr(8'h08, 2'b00, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 0, 0);
        run_instr(8'hD9, 2'b00, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 0, 0);

        mem[16'h1000] = 8'h78; mem[16'h1001] = 8'h56;
        run_instr(8'hE3, 2'b00, 16'h1000, 16'h1234, 16'h0000, 16'h0000, 0, 0);
        run_instr(8'hE3, 2'b10, 16'hFFFF, 16'h0000, 16'h0000, 16'hABCD, 2, 0);
        run_instr(8'hE3, 2'b01, 16'h4000, 16'h0000, 16'h9876, 16'h0000, 1, 2);

        // Abort in WR_HI: nothing completes and the high byte stays unwritten.
        keep_hi = mem[16'h2001];
        log_q.delete();
        @(negedge clk);
        opcode = 8'hE3; prefix = 2'b00; sp_in = 16'h2000; hl_in = 16'h4321; wait_n = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mem_req && mem_we) found = 1;
            else @(negedge clk);
        end
        chk("reach_wr_hi", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ctrl", {busy, done, illegal, swap_de_hl, swap_af, swap_exx, mem_req, mem_we,
                           wr_en}, 0);
        chk("abort_data", {mem_addr, mem_wdata, wr_sel, wr_data, tcycles}, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || wr_en || busy) seen = 1;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_mem", mem[16'h2001], keep_hi);
        run_instr(8'hEB, 2'b00, 16'h0000, 16'h5555, 16'h0000, 16'h0000, 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 8'hEB;
                1: op = 8'h08;
                2: op = 8'hD9;
                3: op = 8'hE3;
                default: op = 8'($urandom);
            endcase
            sp = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_instr(op, 2'($urandom), sp, 16'($urandom), 16'($urandom), 16'($urandom),
                      int'($urandom_range(0, 2)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
